// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the comparator arbiter.
//   cond_t      : 3-bit condition code evaluated on a compare result
//   rsp_state_t : occupancy of the one-entry response register
//   eval_cond() : folds (lessThan, equal) into a single condition bit
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [2:0] {
      EQ     = 3'd0,
      NE     = 3'd1,
      LT     = 3'd2,
      GE     = 3'd3,
      LE     = 3'd4,
      GT     = 3'd5,
      ALWAYS = 3'd6,
      NEVER  = 3'd7
   } cond_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } rsp_state_t;

   // Evaluate a condition code from the two primitive compare flags.
   function automatic logic eval_cond(input cond_t cond, input logic lt, input logic eq);
      logic result;
      result = 1'b0;
      case (cond)
         EQ:      result = eq;
         NE:      result = !eq;
         LT:      result = lt;
         GE:      result = !lt;
         LE:      result = lt | eq;
         GT:      result = !(lt | eq);
         ALWAYS:  result = 1'b1;
         NEVER:   result = 1'b0;
         default: result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/comparator_arbiter_comparator.sv
// -----------------------------------------------------------------------------
// Comparator
// Purely combinational magnitude/equality compare of two BITS-wide operands.
// Ports:
//   a, b      in  BITS  operands, compared exactly as given (no extension)
//   unsign    in  1     1 = unsigned compare, 0 = two's-complement compare
//   lessThan  out 1     a < b under the selected signedness
//   equal     out 1     a == b
// -----------------------------------------------------------------------------
module Comparator #(
   parameter int BITS = 32
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            unsign,
   output logic            lessThan,
   output logic            equal
);

   always_comb begin
      equal = (a == b);
      if (unsign) begin
         lessThan = (a < b);
      end else begin
         lessThan = ($signed(a) < $signed(b));
      end
   end

endmodule

// File: rtl/comparator_arbiter.sv
// -----------------------------------------------------------------------------
// comparator_arbiter
// Shares a single Comparator among REQUESTERS clients. A round-robin pick
// selects one valid requester per cycle, its operands are compared
// combinationally and the result is captured in a one-entry response register
// tagged with the requester index.
// Ports:
//   clk, reset    clock (rising edge) and synchronous active-high reset
//   req_valid     per-requester request valid
//   req_ready     per-requester accept, one-hot or zero
//   req_a, req_b  packed operands, requester i at [i*BITS +: BITS]
//   req_unsign    per-requester unsigned-compare select
//   req_cond      packed 3-bit condition codes (cond_t), requester i at [i*3 +: 3]
//   rsp_valid     response register holds a result
//   rsp_ready     consumer takes the response this cycle
//   rsp_id        requester index of the held response
//   rsp_lessThan  registered a < b
//   rsp_equal     registered a == b
//   rsp_cond      registered condition-code evaluation
// -----------------------------------------------------------------------------
module comparator_arbiter
   import alu_pkg::*;
#(
   parameter  int BITS       = 32,
   parameter  int REQUESTERS = 2,
   localparam int ID_BITS    = $clog2(REQUESTERS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [REQUESTERS-1:0]      req_valid,
   output logic [REQUESTERS-1:0]      req_ready,
   input  logic [REQUESTERS*BITS-1:0] req_a,
   input  logic [REQUESTERS*BITS-1:0] req_b,
   input  logic [REQUESTERS-1:0]      req_unsign,
   input  logic [REQUESTERS*3-1:0]    req_cond,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_BITS-1:0]         rsp_id,
   output logic                       rsp_lessThan,
   output logic                       rsp_equal,
   output logic                       rsp_cond
);

   // Index width for the doubled request vector used by the wrap-around search.
   localparam int                  IDX_BITS = $clog2(2 * REQUESTERS);
   localparam logic [IDX_BITS-1:0] REQ_IDX  = IDX_BITS'(REQUESTERS);
   localparam logic [ID_BITS-1:0]  LAST_ID  = ID_BITS'(REQUESTERS - 1);

   // ------------------------------------------------------------------------
   // Per-requester views of the packed request buses
   // ------------------------------------------------------------------------
   logic [BITS-1:0] a_arr      [REQUESTERS];
   logic [BITS-1:0] b_arr      [REQUESTERS];
   cond_t           cond_arr   [REQUESTERS];

   for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
      assign a_arr[gi]    = req_a[gi*BITS +: BITS];
      assign b_arr[gi]    = req_b[gi*BITS +: BITS];
      assign cond_arr[gi] = cond_t'(req_cond[gi*3 +: 3]);
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   rsp_state_t         state_reg;
   rsp_state_t         state_next;
   logic [ID_BITS-1:0] rr_ptr_reg;
   logic [ID_BITS-1:0] rr_ptr_next;

   logic               rsp_id_valid_unused;
   logic [ID_BITS-1:0] rsp_id_reg;
   logic               rsp_lt_reg;
   logic               rsp_eq_reg;
   logic               rsp_cond_reg;

   // ------------------------------------------------------------------------
   // Round-robin pick: scan a doubled copy of req_valid starting at rr_ptr so
   // the wrap-around needs no modulo inside the loop body.
   // ------------------------------------------------------------------------
   logic [2*REQUESTERS-1:0] valid_dbl;
   logic                    grant_found;
   logic [ID_BITS-1:0]      grant_id;
   logic [IDX_BITS-1:0]     scan_idx;

   assign valid_dbl = {req_valid, req_valid};

   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         scan_idx = IDX_BITS'(rr_ptr_reg) + IDX_BITS'(k);
         if (!grant_found && valid_dbl[scan_idx]) begin
            grant_found = 1'b1;
            if (scan_idx >= REQ_IDX) begin
               grant_id = ID_BITS'(scan_idx - REQ_IDX);
            end else begin
               grant_id = ID_BITS'(scan_idx);
            end
         end
      end
   end

   // Pointer moves to the requester after the one just granted.
   assign rr_ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

   // ------------------------------------------------------------------------
   // Shared comparator fed by the granted requester's operands
   // ------------------------------------------------------------------------
   logic cmp_lt;
   logic cmp_eq;
   logic cmp_cond;

   Comparator #(
      .BITS(BITS)
   ) u_comparator (
      .a        (a_arr[grant_id]),
      .b        (b_arr[grant_id]),
      .unsign   (req_unsign[grant_id]),
      .lessThan (cmp_lt),
      .equal    (cmp_eq)
   );

   assign cmp_cond = eval_cond(cond_arr[grant_id], cmp_lt, cmp_eq);

   // ------------------------------------------------------------------------
   // Control: the response slot can take a new result when empty, or when the
   // held result is being drained this same cycle (keeps 1 result/cycle).
   // ------------------------------------------------------------------------
   logic can_accept;
   logic transfer;

   assign can_accept = (state_reg == EMPTY) || rsp_ready;

   // FSM process 1: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM process 2: next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: begin
            if (transfer) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (transfer) begin
               state_next = FULL;
            end else if (rsp_ready) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   // FSM process 3: outputs. Grants are suppressed while reset is asserted so
   // nothing is accepted in a cycle whose result would be discarded.
   always_comb begin
      transfer  = 1'b0;
      req_ready = '0;
      if (!reset && can_accept && grant_found) begin
         transfer            = 1'b1;
         req_ready[grant_id] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Response register and arbitration pointer. Data registers only load on a
   // transfer; after a drain they keep stale values behind rsp_valid=0.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_id_reg   <= '0;
         rsp_lt_reg   <= 1'b0;
         rsp_eq_reg   <= 1'b0;
         rsp_cond_reg <= 1'b0;
         rr_ptr_reg   <= '0;
      end else if (transfer) begin
         rsp_id_reg   <= grant_id;
         rsp_lt_reg   <= cmp_lt;
         rsp_eq_reg   <= cmp_eq;
         rsp_cond_reg <= cmp_cond;
         rr_ptr_reg   <= rr_ptr_next;
      end
   end

   assign rsp_id_valid_unused = 1'b0;
   assign rsp_valid    = (state_reg == FULL) | rsp_id_valid_unused;
   assign rsp_id       = rsp_id_reg;
   assign rsp_lessThan = rsp_lt_reg;
   assign rsp_equal    = rsp_eq_reg;
   assign rsp_cond     = rsp_cond_reg;

endmodule

// File: tb/tb_comparator_arbiter.sv
// -----------------------------------------------------------------------------
// tb_comparator_arbiter
// Directed stimulus with hand-computed expectations. The stimulus process
// pushes the expected response for every accepted request into a queue; a
// separate monitor pops and compares whenever the DUT presents a response
// that the consumer takes.
// -----------------------------------------------------------------------------
module tb_comparator_arbiter;
   import alu_pkg::*;

   localparam int BITS       = 32;
   localparam int REQUESTERS = 2;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [REQUESTERS-1:0]      req_valid;
   logic [REQUESTERS-1:0]      req_ready;
   logic [REQUESTERS*BITS-1:0] req_a;
   logic [REQUESTERS*BITS-1:0] req_b;
   logic [REQUESTERS-1:0]      req_unsign;
   logic [REQUESTERS*3-1:0]    req_cond;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [0:0]                 rsp_id;
   logic                       rsp_lessThan;
   logic                       rsp_equal;
   logic                       rsp_cond;

   always #5 clk = ~clk;

   comparator_arbiter #(
      .BITS       (BITS),
      .REQUESTERS (REQUESTERS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_unsign   (req_unsign),
      .req_cond     (req_cond),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_lessThan (rsp_lessThan),
      .rsp_equal    (rsp_equal),
      .rsp_cond     (rsp_cond)
   );

   typedef struct packed {
      logic id;
      logic lt;
      logic eq;
      logic cnd;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic id, input logic lt, input logic eq, input logic cnd);
      exp_t e;
      e.id  = id;
      e.lt  = lt;
      e.eq  = eq;
      e.cnd = cnd;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic u, input cond_t c);
      req_a[i*BITS +: BITS] = a;
      req_b[i*BITS +: BITS] = b;
      req_unsign[i]         = u;
      req_cond[i*3 +: 3]    = c;
      req_valid[i]          = 1'b1;
   endtask

   // Check the grant vector at mid-cycle.
   task automatic expect_ready(input string name, input logic [1:0] exp);
      @(negedge clk);
      chk(name, {62'd0, req_ready}, {62'd0, exp});
   endtask

   // ------------------------------------------------------------------------
   // Monitor: one line per consumed response, compared against the queue.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && rsp_valid && rsp_ready) begin
         $display("rsp id=%0d lt=%0b eq=%0b cond=%0b", rsp_id, rsp_lessThan, rsp_equal, rsp_cond);
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL rsp_unexpected: got response id=%0d, required none", rsp_id);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id",       {63'd0, rsp_id},       {63'd0, e.id});
            chk("rsp_lessThan", {63'd0, rsp_lessThan}, {63'd0, e.lt});
            chk("rsp_equal",    {63'd0, rsp_equal},    {63'd0, e.eq});
            chk("rsp_cond",     {63'd0, rsp_cond},     {63'd0, e.cnd});
         end
      end
   end

   // Requester protocol: valid may not drop before its transfer.
   logic [1:0] pend = 2'b00;
   always @(negedge clk) begin
      if (!reset && ((pend & ~req_valid) != 2'b00)) begin
         $error("requester valid dropped before transfer: pend=%b valid=%b", pend, req_valid);
      end
      pend <= req_valid & ~req_ready;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   logic exp_cond_tbl [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin : stimulus
      reset      = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_unsign = '0;
      req_cond   = '0;
      rsp_ready  = 1'b1;

      // Reset: no grants even with both requesters valid; outputs cleared.
      step();
      step();
      req_valid = 2'b11;
      expect_ready("reset_ready", 2'b00);
      chk("reset_rsp", {59'd0, rsp_valid, rsp_id, rsp_lessThan, rsp_equal, rsp_cond}, 64'd0);
      step();
      req_valid = 2'b00;
      step();
      reset = 1'b0;

      // Single request, 1-cycle latency, then drain.
      set_req(0, 32'd5, 32'd7, 1'b0, LT);
      expect_ready("t1_ready", 2'b01);
      push(1'b0, 1'b1, 1'b0, 1'b1);
      step();
      req_valid = 2'b00;
      @(negedge clk);
      chk("t1_latency", {63'd0, rsp_valid}, 64'd1);
      step();
      @(negedge clk);
      chk("t1_drain", {63'd0, rsp_valid}, 64'd0);

      // Signedness on requester 1.
      step();
      set_req(1, 32'hFFFF_FFFF, 32'd1, 1'b0, GE);
      expect_ready("sign_s_ready", 2'b10);
      push(1'b1, 1'b1, 1'b0, 1'b0);
      step();
      set_req(1, 32'hFFFF_FFFF, 32'd1, 1'b1, GE);
      expect_ready("sign_u_ready", 2'b10);
      push(1'b1, 1'b0, 1'b0, 1'b1);

      // Fairness: both valid, grants alternate with no bubbles.
      step();
      set_req(0, 32'd1, 32'd2, 1'b0, EQ);
      set_req(1, 32'd3, 32'd3, 1'b0, EQ);
      for (int n = 0; n < 4; n++) begin
         if (n % 2 == 0) begin
            expect_ready("fair_ready0", 2'b01);
            push(1'b0, 1'b1, 1'b0, 1'b0);
         end else begin
            expect_ready("fair_ready1", 2'b10);
            push(1'b1, 1'b0, 1'b1, 1'b1);
         end
         step();
      end

      // Backpressure: held response stays put, nothing granted.
      rsp_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         expect_ready("bp_ready", 2'b00);
         chk("bp_hold", {59'd0, rsp_valid, rsp_id, rsp_lessThan, rsp_equal, rsp_cond},
             {59'd0, 5'b11011});
         step();
      end
      rsp_ready = 1'b1;
      expect_ready("bp_release_ready", 2'b01);
      push(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      req_valid = 2'b10;
      expect_ready("bp_next_ready", 2'b10);
      push(1'b1, 1'b0, 1'b1, 1'b1);

      // Condition sweep with a == b.
      for (int c = 0; c < 8; c++) begin
         step();
         req_valid = 2'b00;
         set_req(0, 32'd42, 32'd42, 1'b0, cond_t'(c));
         expect_ready("cond_ready", 2'b01);
         push(1'b0, 1'b0, 1'b1, exp_cond_tbl[c]);
      end

      // Reset while FULL and stalled.
      step();
      req_valid = 2'b00;
      set_req(0, 32'd42, 32'd42, 1'b0, NEVER);
      set_req(1, 32'd10, 32'd20, 1'b1, LE);
      expect_ready("prereset_ready", 2'b10);
      push(1'b1, 1'b1, 1'b0, 1'b1);
      step();
      rsp_ready = 1'b0;
      expect_ready("prereset_stall", 2'b00);
      step();
      reset = 1'b1;
      exp_q.delete();
      expect_ready("midreset_ready", 2'b00);
      step();
      reset     = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("reset_drop", {63'd0, rsp_valid}, 64'd0);
      chk("reset_rr_ready", {62'd0, req_ready}, {62'd0, 2'b01});
      push(1'b0, 1'b0, 1'b1, 1'b0);
      step();
      req_valid = 2'b10;
      expect_ready("postreset_ready1", 2'b10);
      push(1'b1, 1'b1, 1'b0, 1'b1);
      step();
      req_valid = 2'b00;
      step();
      step();
      @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
